// File: rtl/mouse_pkg.sv
// Shared definitions for the mouse retiming path.
// Holds the default bus width, the visible-screen limits used as clamp defaults
// and the deepest pipeline the retimer supports.
package mouse_pkg;

    // Default width of the X/Y position buses coming from the PS/2 decoder.
    localparam int unsigned MOUSE_XY_W = 12;

    // Visible area for an 800x600 mode; highest legal coordinate on each axis.
    localparam int unsigned SCREEN_X_MAX = 799;
    localparam int unsigned SCREEN_Y_MAX = 599;

    // Deepest retiming pipeline supported (DEPTH is legal in 1..MOUSE_DEPTH_MAX).
    localparam int unsigned MOUSE_DEPTH_MAX = 8;

    // Warm-up counter width needed to reach DEPTH+1 without wrapping.
    function automatic int unsigned warmup_cnt_w(input int unsigned depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/mouse_event_detect.sv
// Event decoder for the retimed mouse stream.
// Keeps a copy of the previous buffered sample and compares it with the current
// one to produce one-cycle press/release/move strobes. Strobes are decoded only
// from registers, so there is no combinational path from the raw mouse inputs.
//
// Ports:
//   clk_i          pixel clock, rising edge
//   rst_i          synchronous active-high reset
//   cmp_en_i       high once both current and previous samples are post-reset
//   left_i         buffered left-button level
//   x_i, y_i       buffered position
//   left_press_o   0->1 on the buffered button
//   left_release_o 1->0 on the buffered button
//   moved_o        buffered X or Y differs from the previous cycle
module mouse_event_detect
    import mouse_pkg::*;
#(
    parameter int unsigned XY_W = MOUSE_XY_W
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cmp_en_i,
    input  logic            left_i,
    input  logic [XY_W-1:0] x_i,
    input  logic [XY_W-1:0] y_i,
    output logic            left_press_o,
    output logic            left_release_o,
    output logic            moved_o
);

    logic            prev_left_q, prev_left_d;
    logic [XY_W-1:0] prev_x_q, prev_x_d;
    logic [XY_W-1:0] prev_y_q, prev_y_d;

    always_comb begin
        prev_left_d = left_i;
        prev_x_d    = x_i;
        prev_y_d    = y_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_left_q <= 1'b0;
            prev_x_q    <= '0;
            prev_y_q    <= '0;
        end else begin
            prev_left_q <= prev_left_d;
            prev_x_q    <= prev_x_d;
            prev_y_q    <= prev_y_d;
        end
    end

    // cmp_en_i suppresses strobes until the previous-sample register holds
    // real data, so nothing is reported against the cleared post-reset state.
    always_comb begin
        left_press_o   = cmp_en_i & left_i & ~prev_left_q;
        left_release_o = cmp_en_i & ~left_i & prev_left_q;
        moved_o        = cmp_en_i & ((x_i != prev_x_q) | (y_i != prev_y_q));
    end

endmodule

// File: rtl/mouse_signal_pipe.sv
// Mouse-signal retiming pipeline between the PS/2 decoder and the game/draw logic.
// Optionally clamps the position to the visible area, delays button and position
// by DEPTH register stages, flags when the output holds post-reset data and
// produces aligned one-cycle event strobes.
//
// Ports:
//   pclk            pixel clock, all logic on the rising edge
//   rst             synchronous active-high reset
//   mouse_left      raw left-button level
//   mouse_xpos/ypos raw position (unsigned)
//   mouse_*_buf     clamped (if enabled) inputs delayed by exactly DEPTH edges
//   out_valid       pipeline output holds post-reset samples
//   left_press      one-cycle strobe on 0->1 of mouse_left_buf
//   left_release    one-cycle strobe on 1->0 of mouse_left_buf
//   moved           one-cycle strobe when buffered X or Y changed
module mouse_signal_pipe
    import mouse_pkg::*;
#(
    parameter int unsigned XY_W     = MOUSE_XY_W,
    parameter int unsigned DEPTH    = 2,
    parameter bit          CLAMP_EN = 1'b1,
    parameter int unsigned X_MAX    = SCREEN_X_MAX,
    parameter int unsigned Y_MAX    = SCREEN_Y_MAX
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic            mouse_left,
    input  logic [XY_W-1:0] mouse_xpos,
    input  logic [XY_W-1:0] mouse_ypos,
    output logic            mouse_left_buf,
    output logic [XY_W-1:0] mouse_xpos_buf,
    output logic [XY_W-1:0] mouse_ypos_buf,
    output logic            out_valid,
    output logic            left_press,
    output logic            left_release,
    output logic            moved
);

    // Stage word layout: {left, x, y}.
    localparam int unsigned StageW = 2 * XY_W + 1;
    localparam int unsigned CntW   = warmup_cnt_w(DEPTH);

    localparam logic [XY_W-1:0] XLim     = XY_W'(X_MAX);
    localparam logic [XY_W-1:0] YLim     = XY_W'(Y_MAX);
    localparam logic [CntW-1:0] CntValid = CntW'(DEPTH);
    localparam logic [CntW-1:0] CntSat   = CntW'(DEPTH + 1);

    // ------------------------------------------------------------------
    // Input clamp (combinational, ahead of stage 0)
    // ------------------------------------------------------------------
    logic [XY_W-1:0]   x_c;
    logic [XY_W-1:0]   y_c;
    logic [StageW-1:0] stage_in;
    logic [StageW-1:0] stage_out;

    always_comb begin
        x_c = mouse_xpos;
        y_c = mouse_ypos;
        if (CLAMP_EN) begin
            if (mouse_xpos > XLim) x_c = XLim;
            if (mouse_ypos > YLim) y_c = YLim;
        end
        stage_in = {mouse_left, x_c, y_c};
    end

    // ------------------------------------------------------------------
    // Retiming pipeline: stage 0 takes the clamped input, stage k takes k-1
    // ------------------------------------------------------------------
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [StageW-1:0] stage_d;
        logic [StageW-1:0] stage_q;

        if (k == 0) begin : g_head
            assign stage_d = stage_in;
        end else begin : g_body
            assign stage_d = g_stage[k-1].stage_q;
        end

        always_ff @(posedge pclk) begin
            if (rst) begin
                stage_q <= '0;
            end else begin
                stage_q <= stage_d;
            end
        end
    end

    assign stage_out = g_stage[DEPTH-1].stage_q;

    always_comb begin
        mouse_left_buf = stage_out[StageW-1];
        mouse_xpos_buf = stage_out[2*XY_W-1:XY_W];
        mouse_ypos_buf = stage_out[XY_W-1:0];
    end

    // ------------------------------------------------------------------
    // Warm-up counter
    // DEPTH edges fill the pipeline; one more edge fills the previous-sample
    // register, after which comparisons are meaningful.
    // ------------------------------------------------------------------
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            cmp_en;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != CntSat) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        out_valid = (cnt_q >= CntValid);
        cmp_en    = (cnt_q == CntSat);
    end

    // ------------------------------------------------------------------
    // Event strobes
    // ------------------------------------------------------------------
    mouse_event_detect #(
        .XY_W (XY_W)
    ) u_event_detect (
        .clk_i          (pclk),
        .rst_i          (rst),
        .cmp_en_i       (cmp_en),
        .left_i         (mouse_left_buf),
        .x_i            (mouse_xpos_buf),
        .y_i            (mouse_ypos_buf),
        .left_press_o   (left_press),
        .left_release_o (left_release),
        .moved_o        (moved)
    );

endmodule

// File: doc/mouse_signal_pipe.md
Name: mouse_signal_pipe

Overview:
Parametrised mouse-signal retiming pipeline between the PS/2 mouse decoder and the game/draw logic.
- Delays left button, X and Y by a configurable number of register stages.
- Optionally clamps position to the visible screen area.
- Produces aligned one-cycle event strobes for button press, button release and movement, plus an output-valid flag after reset.

Parameters:
XY_W, 12, width of the X/Y position buses
DEPTH, 2, number of register stages on the data path, legal range 1..8
CLAMP_EN, 1, 1 = clamp position at the input stage, 0 = pass position through unmodified
X_MAX, 799, maximum legal X value when CLAMP_EN=1
Y_MAX, 599, maximum legal Y value when CLAMP_EN=1

Ports:
pclk  input  1  pixel clock, all logic on the rising edge
rst  input  1  synchronous reset, active-high
mouse_left  input  1  raw left-button level
mouse_xpos  input  XY_W  raw X position (unsigned)
mouse_ypos  input  XY_W  raw Y position (unsigned)
mouse_left_buf  output  1  left button delayed by DEPTH cycles
mouse_xpos_buf  output  XY_W  X position (clamped if enabled), delayed by DEPTH cycles
mouse_ypos_buf  output  XY_W  Y position (clamped if enabled), delayed by DEPTH cycles
out_valid  output  1  high once the pipeline holds post-reset samples
left_press  output  1  one-cycle strobe on 0->1 of mouse_left_buf
left_release  output  1  one-cycle strobe on 1->0 of mouse_left_buf
moved  output  1  one-cycle strobe when buffered X or Y differs from the previous cycle

Behaviour:
- Reset is synchronous and active-high (rst, sampled on the rising edge of pclk). While rst=1:
  - all pipeline stages, the previous-sample register and the warm-up counter clear to 0;
  - all outputs read 0.
- Reset asserted mid-operation has the same effect on the next edge. No events are generated from pre-reset data.
- Clamp (CLAMP_EN=1): combinational, applied before stage 0.
  - x_c = (mouse_xpos > X_MAX) ? X_MAX : mouse_xpos; y_c likewise with Y_MAX.
  - Unsigned compare at XY_W bits.
  - CLAMP_EN=0: x_c = mouse_xpos, y_c = mouse_ypos.
- Pipeline: stage k (k = 0..DEPTH-1) registers stage k-1; stage 0 registers {mouse_left, x_c, y_c}.
  - Output = stage DEPTH-1.
  - Latency is exactly DEPTH pclk edges from input to *_buf.
- Warm-up counter:
  - width $clog2(DEPTH+2); increments every non-reset edge; saturates at DEPTH+1.
  - out_valid = (cnt >= DEPTH).
  - cmp_en = (cnt == DEPTH+1).
- Previous-sample register: captures {mouse_left_buf, xpos_buf, ypos_buf} every non-reset edge.
- Event strobes are decoded only from registers, with no combinational path from any input:
  - left_press = cmp_en & mouse_left_buf & ~prev_left
  - left_release = cmp_en & ~mouse_left_buf & prev_left
  - moved = cmp_en & ((xpos_buf != prev_x) | (ypos_buf != prev_y))
- Consequences of the strobe rules:
  - left_press and left_release are mutually exclusive.
  - A button held for N cycles gives exactly one press and one release.
  - A one-cycle input glitch gives a press in one cycle and a release in the next.
- moved may coincide with press/release in the same cycle. A clamped input moving beyond the limit produces no moved once the clamped value is steady.
- Stationary input while cmp_en=1 produces no strobes.
- No flow control: one sample is accepted per cycle and nothing is ever dropped.

Decomposition:
- Shared package mouse_pkg:
  - XY_W default;
  - screen limits SCREEN_X_MAX=799 and SCREEN_Y_MAX=599 (used as parameter defaults);
  - localparam for the maximum legal DEPTH (8).
- Natural sub-module: mouse_event_detect. It holds the previous-sample register and the cmp_en-gated strobe decode.
- The pipeline is generated in the top with a generate loop over DEPTH.

Test Plan (DEPTH=2, CLAMP_EN=1, X_MAX=799, Y_MAX=599 unless stated):
- Reset/warm-up: hold rst 3 cycles, then release with inputs x=100, y=50, left=0.
  - All outputs 0 during reset.
  - Buffers read x=100, y=50 after edge 2; out_valid=1 from edge 2.
  - No strobes on edges 1-3.
- Latency: step x from 100 to 200 at cycle 10.
  - mouse_xpos_buf=200 exactly 2 edges later.
  - moved=1 for exactly one cycle, then 0.
- Button: left=1 for cycles 20-24.
  - left_press=1 one cycle only, 2 cycles after the rise.
  - left_release=1 one cycle only, 2 cycles after the fall.
- Clamp: drive x=4000, y=700.
  - Buffers read 799 and 599.
  - Then x=900: no moved strobe. Then x=799: no moved strobe.
  - With CLAMP_EN=0, x=4000 passes through unchanged.
- Mid-run reset: assert rst for 1 cycle while left=1 and the pipeline is full.
  - Outputs and out_valid drop to 0.
  - After release: no left_press until cmp_en=1 (3 edges); press fires only if left was 0 at the previous output cycle.
- Depth sweep: DEPTH=1 and DEPTH=8 with random input streams.
  - Output equals the input delayed by exactly DEPTH cycles.
  - Strobe counts match the reference model.
